writeback_ledger: RTL and testbench

- Sequences the physical-tag resource used by the register renamer.
- Owns a free pool of NTAGS physical tags and allocates one tag per dispatched instruction.
- Records each allocation in an in-order ledger, marks entries done on writeback, and retires them in program order, returning their tags to the pool.
- Sits between pending-queue dequeue/decode and the execution-unit writeback bus; flush supports mispredict/clear recovery.

---
 rtl/writeback_ledger.sv | 119 +++++++++++
 tb/tb_writeback_ledger.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_ledger.sv
// Physical-tag allocator plus in-order ledger: grants free tags at dispatch,
// marks entries done on writeback, retires them in program order.
module writeback_ledger #(
    parameter int NTAGS = 32,
    parameter int TAGW  = 5,
    parameter int DEPTH = 16,
    parameter int NRW   = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [NRW-1:0]   alloc_nr,
    output logic             alloc_ready,
    output logic [TAGW-1:0]  alloc_tag,
    input  logic             wb_valid,
    input  logic [TAGW-1:0]  wb_tag,
    output logic             commit_valid,
    input  logic             commit_ready,
    output logic [NRW-1:0]   commit_nr,
    output logic [TAGW-1:0]  commit_tag,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [NTAGS-1:0] free_mask
);

    logic [NTAGS-1:0]           free_q, free_d;
    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0]           done_q, done_d;
    logic [DEPTH-1:0][NRW-1:0]  nr_q, nr_d;
    logic [DEPTH-1:0][TAGW-1:0] tag_q, tag_d;
    logic [PW-1:0]              head_q, head_d;
    logic [PW-1:0]              tail_q, tail_d;
    logic [CW-1:0]              count_q, count_d;
    logic                       alloc_fire, commit_fire;

    // Lowest-index free tag wins; scan from the top so the last hit is the lowest.
    always_comb begin
        alloc_tag = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_tag = TAGW'(i);
        end
    end

    assign alloc_ready  = (count_q != CW'(DEPTH)) && (|free_q);
    assign alloc_fire   = alloc_valid && alloc_ready;
    assign commit_valid = valid_q[tail_q] && done_q[tail_q];
    assign commit_fire  = commit_valid && commit_ready;
    assign commit_nr    = nr_q[tail_q];
    assign commit_tag   = tag_q[tail_q];
    assign count        = count_q;
    assign free_mask    = free_q;

    always_comb begin
        free_d  = free_q;
        valid_d = valid_q;
        done_d  = done_q;
        nr_d    = nr_q;
        tag_d   = tag_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            free_d  = '1;
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_valid && valid_q[i] && (tag_q[i] == wb_tag)) done_d[i] = 1'b1;
            end
            // Commit slot (tail) and alloc slot (head) never collide: that needs
            // the ledger both empty and full at once.
            if (commit_fire) begin
                valid_d[tail_q]        = 1'b0;
                free_d[tag_q[tail_q]]  = 1'b1;
                tail_d                 = tail_q + 1'b1;
            end
            if (alloc_fire) begin
                nr_d[head_q]     = alloc_nr;
                tag_d[head_q]    = alloc_tag;
                done_d[head_q]   = 1'b0;
                valid_d[head_q]  = 1'b1;
                free_d[alloc_tag] = 1'b0;
                head_d           = head_q + 1'b1;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            free_q  <= '1;
            valid_q <= '0;
            done_q  <= '0;
            nr_q    <= '0;
            tag_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            free_q  <= free_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            nr_q    <= nr_d;
            tag_q   <= tag_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_writeback_ledger.sv
// Directed bench for writeback_ledger: hand-computed expectations checked with
// immediate assertions one step after each rising edge.
module tb_writeback_ledger;

    logic        clk = 1'b0;
    logic        rst, alloc_valid, wb_valid, commit_ready, flush;
    logic [3:0]  alloc_nr;
    logic [4:0]  wb_tag;
    logic        alloc_ready, commit_valid;
    logic [4:0]  alloc_tag, commit_tag;
    logic [3:0]  commit_nr;
    logic [4:0]  count;
    logic [31:0] free_mask;
    int          checks = 0;
    int          errors = 0;

    writeback_ledger dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_nr(alloc_nr),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_nr(commit_nr), .commit_tag(commit_tag),
        .flush(flush), .count(count), .free_mask(free_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; alloc_valid = 1'b0; alloc_nr = '0; wb_valid = 1'b0; wb_tag = '0;
        commit_ready = 1'b0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready",  32'(alloc_ready), 32'd1);
        chk("rst_tag",    32'(alloc_tag), 32'd0);
        chk("rst_cvalid", 32'(commit_valid), 32'd0);
        chk("rst_count",  32'(count), 32'd0);
        chk("rst_free",   free_mask, 32'hFFFF_FFFF);

        // Three allocs, tags 0,1,2
        alloc_valid = 1'b1; alloc_nr = 4'd3; chk("a0_tag", 32'(alloc_tag), 32'd0); tick();
        alloc_nr = 4'd5; chk("a1_tag", 32'(alloc_tag), 32'd1); tick();
        alloc_nr = 4'd7; chk("a2_tag", 32'(alloc_tag), 32'd2); tick();
        alloc_valid = 1'b0;
        chk("a_count", 32'(count), 32'd3);
        chk("a_free",  free_mask, 32'hFFFF_FFF8);
        chk("a_cnr_notdone", 32'(commit_nr), 32'd3);
        chk("a_ctag_notdone", 32'(commit_tag), 32'd0);

        // Unmatched wb is ignored
        wb_valid = 1'b1; wb_tag = 5'd20; tick();
        chk("wbmiss_count", 32'(count), 32'd3);
        chk("wbmiss_free", free_mask, 32'hFFFF_FFF8);
        chk("wbmiss_cvalid", 32'(commit_valid), 32'd0);

        // wb of tag 1 is not the oldest
        wb_tag = 5'd1; tick();
        chk("wb1_cvalid", 32'(commit_valid), 32'd0);
        wb_tag = 5'd0;
        chk("wb0_nocomb", 32'(commit_valid), 32'd0);
        tick();
        wb_valid = 1'b0;
        chk("wb0_cvalid", 32'(commit_valid), 32'd1);
        chk("wb0_cnr", 32'(commit_nr), 32'd3);
        chk("wb0_ctag", 32'(commit_tag), 32'd0);

        commit_ready = 1'b1; tick();
        chk("c0_cvalid", 32'(commit_valid), 32'd1);
        chk("c0_cnr", 32'(commit_nr), 32'd5);
        chk("c0_ctag", 32'(commit_tag), 32'd1);
        chk("c0_count", 32'(count), 32'd2);
        chk("c0_free", free_mask, 32'hFFFF_FFF9);
        tick();
        chk("c1_cvalid", 32'(commit_valid), 32'd0);
        chk("c1_cnr", 32'(commit_nr), 32'd7);
        chk("c1_ctag", 32'(commit_tag), 32'd2);
        chk("c1_count", 32'(count), 32'd1);
        chk("c1_free", free_mask, 32'hFFFF_FFFB);
        tick();
        chk("stall_count", 32'(count), 32'd1);
        commit_ready = 1'b0;
        do_flush();

        // Fill to DEPTH
        alloc_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            alloc_nr = 4'(i);
            tick();
        end
        chk("full_count", 32'(count), 32'd16);
        chk("full_ready", 32'(alloc_ready), 32'd0);
        chk("full_free", free_mask, 32'hFFFF_0000);
        chk("full_tag", 32'(alloc_tag), 32'd16);
        alloc_nr = 4'd9; tick();
        chk("full_hold_count", 32'(count), 32'd16);
        chk("full_hold_free", free_mask, 32'hFFFF_0000);
        wb_valid = 1'b1; wb_tag = 5'd0; tick();
        wb_valid = 1'b0;
        chk("full_cvalid", 32'(commit_valid), 32'd1);
        commit_ready = 1'b1;
        chk("full_commit_ready", 32'(alloc_ready), 32'd0);
        tick();
        commit_ready = 1'b0;
        chk("full_c_count", 32'(count), 32'd15);
        chk("full_c_ready", 32'(alloc_ready), 32'd1);
        chk("full_c_tag", 32'(alloc_tag), 32'd0);
        chk("full_c_free", free_mask, 32'hFFFF_0001);
        tick();
        alloc_valid = 1'b0;
        chk("refill_count", 32'(count), 32'd16);
        chk("refill_free", free_mask, 32'hFFFF_0000);
        do_flush();

        // Out-of-order writeback, in-order commit
        alloc_valid = 1'b1;
        alloc_nr = 4'd1; tick();
        alloc_nr = 4'd2; tick();
        alloc_nr = 4'd3; tick();
        alloc_valid = 1'b0;
        wb_valid = 1'b1;
        wb_tag = 5'd2; tick();
        wb_tag = 5'd0; tick();
        wb_tag = 5'd1; tick();
        wb_valid = 1'b0;
        chk("ooo_cvalid", 32'(commit_valid), 32'd1);
        chk("ooo_c0tag", 32'(commit_tag), 32'd0);
        chk("ooo_c0nr", 32'(commit_nr), 32'd1);
        chk("ooo_pre_atag", 32'(alloc_tag), 32'd3);
        commit_ready = 1'b1; tick();
        chk("ooo_c1tag", 32'(commit_tag), 32'd1);
        chk("ooo_c1nr", 32'(commit_nr), 32'd2);
        chk("ooo_regrant", 32'(alloc_tag), 32'd0);
        chk("ooo_free1", free_mask, 32'hFFFF_FFF9);
        tick();
        chk("ooo_c2tag", 32'(commit_tag), 32'd2);
        chk("ooo_c2nr", 32'(commit_nr), 32'd3);
        chk("ooo_free2", free_mask, 32'hFFFF_FFFB);
        tick();
        commit_ready = 1'b0;
        chk("ooo_done_cvalid", 32'(commit_valid), 32'd0);
        chk("ooo_done_count", 32'(count), 32'd0);
        chk("ooo_done_free", free_mask, 32'hFFFF_FFFF);

        // 40 rounds across pointer wrap
        for (int r = 0; r < 40; r++) begin
            alloc_valid = 1'b1; alloc_nr = 4'((r * 7 + 3) % 16); tick();
            alloc_valid = 1'b0;
            wb_valid = 1'b1; wb_tag = 5'd0; tick();
            wb_valid = 1'b0;
            chk("wrap_cvalid", 32'(commit_valid), 32'd1);
            chk("wrap_cnr", 32'(commit_nr), 32'((r * 7 + 3) % 16));
            commit_ready = 1'b1; tick();
            commit_ready = 1'b0;
        end
        chk("wrap_count", 32'(count), 32'd0);
        chk("wrap_free", free_mask, 32'hFFFF_FFFF);

        // Flush with 5 in flight plus alloc/wb/commit in the same cycle
        alloc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alloc_nr = 4'(i);
            tick();
        end
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 5'd0; tick();
        chk("pre_flush_count", 32'(count), 32'd5);
        flush = 1'b1; alloc_valid = 1'b1; wb_tag = 5'd1; commit_ready = 1'b1; tick();
        flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0; commit_ready = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_cvalid", 32'(commit_valid), 32'd0);
        chk("flush_free", free_mask, 32'hFFFF_FFFF);
        chk("flush_atag", 32'(alloc_tag), 32'd0);

        // Same via rst mid-operation
        alloc_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alloc_nr = 4'(i);
            tick();
        end
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_tag = 5'd0; tick();
        chk("pre_rst_count", 32'(count), 32'd5);
        rst = 1'b1; alloc_valid = 1'b1; wb_tag = 5'd1; commit_ready = 1'b1; tick();
        rst = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0; commit_ready = 1'b0;
        chk("rst2_count", 32'(count), 32'd0);
        chk("rst2_cvalid", 32'(commit_valid), 32'd0);
        chk("rst2_free", free_mask, 32'hFFFF_FFFF);
        chk("rst2_ready", 32'(alloc_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
